rx_frame_ctrl: RTL
==================

// Module: rx_frame_ctrl
// PURPOSE
//  Receive-side frame delimiter FSM; sits between the XGMII 64-bit receive interface and the rx byte/word counter.
//  Detects Start/Terminate/Error control characters, drives the counter's load/en strobes and measures
//  frame length (bytes after SFD up to Terminate, FCS included).
//  Flags runt, oversize and coding-error frames for the downstream rx buffer.
// PARAMETERS
//  LEN_WIDTH   16    width of frame_len; length saturates at 2^LEN_WIDTH-1
//  MIN_FRAME   64    smallest legal length (bytes)
//  MAX_FRAME   1518  largest legal length when jumbo support is compiled out
//  JUMBO_MAX   9018  largest legal length when RX_JUMBO_EN is defined
// PORTS
//  clk          in   1          receive clock; all logic on rising edge
//  reset        in   1          asynchronous, active-high reset
//  rxd_in       in   64         XGMII data; lane k = rxd_in[8k+7:8k]
//  rxc_in       in   8          XGMII control; rxc_in[k]=1 => lane k is a control char
//  cnt_load     out  1          clear strobe to word counter
//  cnt_en       out  1          increment strobe to word counter (one per data word)
//  in_frame     out  1          high while a frame is being received
//  frame_done   out  1          one-cycle pulse at end of every frame (good or bad)
//  frame_good   out  1          qualifies frame_done: length in range, no error
//  too_short    out  1          qualifies frame_done: len < MIN_FRAME
//  too_long     out  1          qualifies frame_done: len > max bound
//  code_err     out  1          qualifies frame_done: error char / bad control / abort
//  frame_len    out  LEN_WIDTH  byte length, valid while frame_done=1
// BEHAVIOUR
//  - Reset: all outputs 0, FSM IDLE, internal length 0. Reset mid-frame discards the frame; no frame_done.
//  - Start: lane0 rxc[0]=1 & 0xFB, or lane4 rxc[4]=1 & 0xFB (lanes 0-3 idle).
//  - States: IDLE, PRE4, DATA.
//      IDLE --start lane0--> DATA
//      IDLE --start lane4--> PRE4
//      PRE4 --next word--> DATA (adds 4 bytes: lanes 4-7)
//      DATA --T-->         IDLE
//  - DATA word with rxc=0 adds 8 bytes.
//  - DATA word whose first control lane k holds 0xFD (Terminate) adds k bytes; the frame ends.
//  - Terminate in PRE4 also ends the frame, with 0 bytes added from that word.
//  - In DATA/PRE4, any of the following sets a sticky error for the current frame:
//      control lane before T that is not 0xFD;
//      0xFE in any lane;
//      control lane in PRE4 other than a T.
//    Reception continues to T.
//  - Start char while in DATA/PRE4 (no T):
//      ends the current frame with code_err=1;
//      the new frame begins in the same cycle (IDLE state skipped).
//  - Length arithmetic: unsigned, saturating at all-ones; never wraps.
//  - cnt_load: pulses 1 cycle, registered, the cycle after a Start is sampled.
//  - cnt_en: high, registered, one cycle after each DATA-state word carrying >=1 data byte.
//  - in_frame: 1 from the cycle after Start through the cycle frame_done pulses.
//  - frame_done and its qualifiers: registered; valid exactly 1 cycle after the word holding T.
//  - frame_good = ~too_short & ~too_long & ~code_err. Flags are not mutually exclusive except vs frame_good.
//  - Words seen in IDLE without Start (idles, errors) are ignored.
// CONFIGURATION
//  RX_JUMBO_EN defined:     upper bound = JUMBO_MAX; too_long only when len > JUMBO_MAX.
//  RX_JUMBO_EN not defined: upper bound = MAX_FRAME; JUMBO_MAX unused.
// TESTING
//  - Lane0 start, 8 data words (rxc=0), T lane0 -> frame_len=64, frame_good=1, 8 cnt_en pulses, 1 cnt_load.
//  - Lane0 start, 7 data words, T lane4 -> frame_len=60, too_short=1, frame_good=0.
//  - Lane4 start, 7 data words, T lane4 -> frame_len=4+56+4=64, frame_good=1.
//  - 0xFE in lane 2 of data word 3 of a 64-byte frame -> frame_len=64, code_err=1, frame_good=0.
//  - 1519-byte frame:
//      without RX_JUMBO_EN -> too_long=1;
//      with RX_JUMBO_EN    -> frame_good=1;
//      9019 bytes with RX_JUMBO_EN -> too_long=1.
//  - Reset asserted mid-frame (word 4) -> all outputs 0 next edge, no frame_done; following 64-byte frame good.
//  - Second Start at word 5 of a frame -> frame_done with code_err=1, len=32; new frame counted from that Start.

Source files
------------

// File: rtl/rx_frame_ctrl_if.sv
// XGMII receive word plus frame-delimiter status and counter strobes.
// master: drives rxd_in/rxc_in and observes status. slave: rx_frame_ctrl.
interface rx_frame_ctrl_if #(
    parameter int unsigned LEN_WIDTH = 16
);
    logic [63:0]          rxd_in;
    logic [7:0]           rxc_in;
    logic                 cnt_load;
    logic                 cnt_en;
    logic                 in_frame;
    logic                 frame_done;
    logic                 frame_good;
    logic                 too_short;
    logic                 too_long;
    logic                 code_err;
    logic [LEN_WIDTH-1:0] frame_len;

    modport master (
        output rxd_in, rxc_in,
        input  cnt_load, cnt_en, in_frame, frame_done, frame_good,
               too_short, too_long, code_err, frame_len
    );

    modport slave (
        input  rxd_in, rxc_in,
        output cnt_load, cnt_en, in_frame, frame_done, frame_good,
               too_short, too_long, code_err, frame_len
    );
endinterface

// File: rtl/rx_frame_ctrl.sv
// Receive-side XGMII frame delimiter: finds Start/Terminate, measures frame
// length after the SFD (FCS included), strobes the word counter and flags
// runt / oversize / coding-error frames.
// Optional feature macro: RX_JUMBO_EN raises the upper length bound to JUMBO_MAX.
module rx_frame_ctrl #(
    parameter int unsigned LEN_WIDTH = 16,
    parameter int unsigned MIN_FRAME = 64,
    parameter int unsigned MAX_FRAME = 1518,
    parameter int unsigned JUMBO_MAX = 9018
) (
    input  logic           clk,
    input  logic           reset,
    rx_frame_ctrl_if.slave rx
);

`ifdef RX_JUMBO_EN
    localparam bit JUMBO_EN = 1'b1;
`else
    localparam bit JUMBO_EN = 1'b0;
`endif
    localparam int unsigned MAX_LEN = JUMBO_EN ? JUMBO_MAX : MAX_FRAME;
    localparam logic [LEN_WIDTH-1:0] MIN_L = LEN_WIDTH'(MIN_FRAME);
    localparam logic [LEN_WIDTH-1:0] MAX_L = LEN_WIDTH'(MAX_LEN);
    localparam logic [7:0] CH_START = 8'hFB;
    localparam logic [7:0] CH_TERM  = 8'hFD;
    localparam logic [7:0] CH_IDLE  = 8'h07;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE4 = 2'd1,
        DATA = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic                 err_q, err_d;
    logic                 load_q, load_d;
    logic                 en_q, en_d;
    logic                 inf_q, inf_d;
    logic                 done_q, done_d;
    logic                 good_q, good_d;
    logic                 short_q, short_d;
    logic                 long_q, long_d;
    logic                 cerr_q, cerr_d;
    logic [LEN_WIDTH-1:0] flen_q, flen_d;

    logic [7:0]           is_term;
    logic [7:0]           before_t;
    logic [3:0]           t_lane;
    logic                 t_found;
    logic                 ctl_err;
    logic                 lanes03_idle;
    logic                 start0;
    logic                 start4;

    // Word decode: lowest Terminate lane, control chars ahead of it, Start patterns
    always_comb begin
        is_term      = '0;
        before_t     = '0;
        t_lane       = 4'd8;
        lanes03_idle = 1'b1;
        for (int k = 0; k < 8; k++) begin
            is_term[k] = rx.rxc_in[k] && (rx.rxd_in[8*k +: 8] == CH_TERM);
        end
        for (int k = 7; k >= 0; k--) begin
            if (is_term[k]) t_lane = 4'(k);
        end
        for (int k = 0; k < 8; k++) begin
            before_t[k] = (4'(k) < t_lane);
        end
        for (int k = 0; k < 4; k++) begin
            lanes03_idle = lanes03_idle && rx.rxc_in[k] && (rx.rxd_in[8*k +: 8] == CH_IDLE);
        end
        t_found = |is_term;
        ctl_err = |(rx.rxc_in & before_t);
        start0  = rx.rxc_in[0] && (rx.rxd_in[7:0] == CH_START);
        start4  = lanes03_idle && rx.rxc_in[4] && (rx.rxd_in[39:32] == CH_START);
    end

    logic [3:0]           add_c;
    logic [LEN_WIDTH:0]   sum_w;
    logic [LEN_WIDTH-1:0] len_sum;
    logic                 fin;
    logic                 fin_err;
    logic [LEN_WIDTH-1:0] fin_len;

    // Next state, length accumulation and end-of-frame qualification
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        err_d   = err_q;
        load_d  = 1'b0;
        en_d    = 1'b0;
        inf_d   = 1'b0;
        done_d  = 1'b0;
        good_d  = 1'b0;
        short_d = 1'b0;
        long_d  = 1'b0;
        cerr_d  = 1'b0;
        flen_d  = '0;
        fin     = 1'b0;
        fin_err = 1'b0;
        fin_len = '0;

        if (state_q == PRE4) begin
            add_c = t_found ? 4'd0 : 4'd4;
        end else begin
            add_c = t_found ? t_lane : 4'd8;
        end
        sum_w   = {1'b0, len_q} + (LEN_WIDTH + 1)'(add_c);
        len_sum = sum_w[LEN_WIDTH] ? '1 : sum_w[LEN_WIDTH-1:0];

        case (state_q)
            IDLE: begin
                if (start0 || start4) begin
                    state_d = start0 ? DATA : PRE4;
                    len_d   = '0;
                    err_d   = 1'b0;
                    load_d  = 1'b1;
                    inf_d   = 1'b1;
                end
            end
            PRE4, DATA: begin
                inf_d = 1'b1;
                if (t_found) begin
                    fin     = 1'b1;
                    fin_len = len_sum;
                    fin_err = err_q || ctl_err;
                    en_d    = (state_q == DATA) && (add_c != 4'd0);
                    state_d = IDLE;
                    len_d   = '0;
                    err_d   = 1'b0;
                end else if (start0 || start4) begin
                    // Abort current frame; the new one starts on this same word
                    fin     = 1'b1;
                    fin_len = len_q;
                    fin_err = 1'b1;
                    state_d = start0 ? DATA : PRE4;
                    len_d   = '0;
                    err_d   = 1'b0;
                    load_d  = 1'b1;
                end else begin
                    len_d   = len_sum;
                    err_d   = err_q || ctl_err;
                    en_d    = (state_q == DATA);
                    state_d = (state_q == PRE4) ? DATA : state_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (fin) begin
            done_d  = 1'b1;
            flen_d  = fin_len;
            short_d = fin_len < MIN_L;
            long_d  = fin_len > MAX_L;
            cerr_d  = fin_err;
            good_d  = !(short_d || long_d || fin_err);
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            len_q   <= '0;
            err_q   <= 1'b0;
            load_q  <= 1'b0;
            en_q    <= 1'b0;
            inf_q   <= 1'b0;
            done_q  <= 1'b0;
            good_q  <= 1'b0;
            short_q <= 1'b0;
            long_q  <= 1'b0;
            cerr_q  <= 1'b0;
            flen_q  <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            err_q   <= err_d;
            load_q  <= load_d;
            en_q    <= en_d;
            inf_q   <= inf_d;
            done_q  <= done_d;
            good_q  <= good_d;
            short_q <= short_d;
            long_q  <= long_d;
            cerr_q  <= cerr_d;
            flen_q  <= flen_d;
        end
    end

    assign rx.cnt_load   = load_q;
    assign rx.cnt_en     = en_q;
    assign rx.in_frame   = inf_q;
    assign rx.frame_done = done_q;
    assign rx.frame_good = good_q;
    assign rx.too_short  = short_q;
    assign rx.too_long   = long_q;
    assign rx.code_err   = cerr_q;
    assign rx.frame_len  = flen_q;

endmodule
